// File: rtl/meta_info_reader.sv
// Walks one NUL-terminated string out of the meta-info character ROM and streams it
// over a valid/ready interface, waiting SETTLE_CYCLES for the ROM before each sample.
module meta_info_reader #(
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_LEN       = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_proj,
  input  logic        abort,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        out_last,
  output logic [5:0]  out_count,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_TERM} state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [5:0] LAST_CHR = 6'(MAX_LEN - 1);

  state_t     state;
  logic [5:0] proj_q;
  logic [5:0] chr_q;
  logic [7:0] cnt;

  assign req_ready = (state == S_IDLE) && !abort;
  assign out_valid = (state == S_EMIT) || (state == S_TERM);
  assign busy      = (state != S_IDLE);
  assign rom_addr  = {proj_q, chr_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      proj_q    <= '0;
      chr_q     <= '0;
      cnt       <= '0;
      out_char  <= '0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else if (abort) begin
      // A beat handshaking alongside abort is still counted as delivered.
      if (state != S_IDLE) begin
        if (out_valid && out_ready && !out_last)
          out_count <= out_count + 6'd1;
        out_last <= 1'b0;
        state    <= S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            proj_q    <= req_proj;
            chr_q     <= '0;
            cnt       <= CNT_INIT;
            out_count <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            out_char <= rom_data;
            out_last <= (rom_data == 8'h00);
            state    <= S_EMIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state <= S_IDLE;
            end else begin
              out_count <= out_count + 6'd1;
              if (chr_q == LAST_CHR) begin
                // Length limit hit without a NUL: synthesize the terminator.
                out_char <= 8'h00;
                out_last <= 1'b1;
                state    <= S_TERM;
              end else begin
                chr_q <= chr_q + 6'd1;
                cnt   <= CNT_INIT;
                state <= S_WAIT;
              end
            end
          end
        end
        S_TERM: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
